// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared screen geometry, pixel record and colour constants
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  localparam logic [COLOUR_W-1:0] BLACK = 3'd0;
  localparam logic [COLOUR_W-1:0] GREEN = 3'd2;
endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - single-clock FIFO of pixel_t records
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   push,
  input  pixel_t                 push_data,
  input  logic                   pop,
  output pixel_t                 pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  pixel_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - round-robin pixel arbiter with clipping, FIFO and registered plot port
module plot_arbiter
  import vga_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                valid0,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [COLOUR_W-1:0] colour0,
  output logic                ready0,
  input  logic                valid1,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour1,
  output logic                ready1,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                idle,
  output logic [7:0]          drop_count
);
  localparam int              CW    = $clog2(DEPTH) + 1;
  localparam logic [X_W-1:0]  X_LIM = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0]  Y_LIM = Y_W'(SCREEN_H);

  logic            prio;
  logic            space;
  logic            accept;
  logic            in_range;
  logic            push;
  logic            drop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  pixel_t          sel;
  pixel_t          head;
  pixel_t          pix_q;

  // Grants are held off while resetn is low so no source sees a handshake during reset.
  assign space = !fifo_full && resetn;

  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (space) begin
      if (valid0 && (!valid1 || !prio)) ready0 = 1'b1;
      else if (valid1)                  ready1 = 1'b1;
    end
  end

  assign accept   = ready0 || ready1;
  assign sel      = ready0 ? pixel_t'{x0, y0, colour0} : pixel_t'{x1, y1, colour1};
  assign in_range = (sel.x < X_LIM) && (sel.y < Y_LIM);
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push),
    .push_data (sel),
    .pop       (!fifo_empty),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pix_q      <= '0;
      plot       <= 1'b0;
      prio       <= 1'b0;
      drop_count <= '0;
    end else begin
      plot <= !fifo_empty;
      if (!fifo_empty) pix_q <= head;
      // Priority passes to whichever source did not just transfer.
      if (accept) prio <= ready0;
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 1'b1;
    end
  end

  assign x      = pix_q.x;
  assign y      = pix_q.y;
  assign colour = pix_q.colour;
  assign idle   = (fifo_count == '0) && !plot && !valid0 && !valid1;
endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Sits downstream of the per-object drawing datapaths (player and obstacle) and upstream of the VGA adapter's single pixel-write port.
- Accepts pixel-write requests (x, y, colour) from two sources over valid/ready handshakes and arbitrates between them round-robin.
- Clips anything outside the 160x120 screen and buffers accepted pixels in a small FIFO.
- Emits at most one plot per clock to the adapter, and reports idle so the game control FSM knows when all queued drawing has landed.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- SCREEN_W, 160, valid x range 0..SCREEN_W-1
- SCREEN_H, 120, valid y range 0..SCREEN_H-1

Ports:
- clock  in  1  system clock (50 MHz)
- resetn  in  1  asynchronous active-low reset
- valid0  in  1  source 0 (player) pixel request
- x0  in  8  source 0 x
- y0  in  7  source 0 y
- colour0  in  3  source 0 colour
- ready0  out  1  source 0 request accepted this cycle
- valid1  in  1  source 1 (obstacle) pixel request
- x1  in  8  source 1 x
- y1  in  7  source 1 y
- colour1  in  3  source 1 colour
- ready1  out  1  source 1 request accepted this cycle
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- plot  out  1  write enable to VGA adapter
- idle  out  1  FIFO empty, plot low, no valid pending
- drop_count  out  8  saturating count of clipped pixels

Behaviour:
- Reset (resetn low, asynchronous):
  - x=0, y=0, colour=0, plot=0, drop_count=0.
  - FIFO empty; round-robin pointer gives priority to source 0.
  - Holds as long as resetn is low, including mid-burst: FIFO contents are discarded and no partial plot is emitted.
- Handshake:
  - A transfer occurs on an edge where valid_n && ready_n.
  - Sources hold x/y/colour stable while valid is high and not yet accepted.
- Grant (combinational, same cycle):
  - space = !full. Space means the FIFO is not full; a pop in the same cycle does not create space.
  - If space is low, ready0=ready1=0.
  - If exactly one source is valid, that source gets ready.
  - If both are valid, the prioritised source gets ready.
  - At most one ready is high per cycle.
- Round-robin: after every accepted transfer from source n, priority moves to the other source. With no transfer, the pointer is unchanged.
- Clipping:
  - An accepted pixel with x>=SCREEN_W or y>=SCREEN_H completes its handshake but is not pushed.
  - drop_count increments by 1 and saturates at 255.
  - In-range pixels are pushed as {x,y,colour}, 18 bits.
- Output stage (registered):
  - If the FIFO is non-empty at an edge, the head is popped into x/y/colour and plot=1 for the following cycle.
  - If the FIFO is empty, plot=0 and x/y/colour hold their last values.
  - Latency: an in-range pixel accepted at edge k into an empty FIFO drives plot=1 between edges k+1 and k+2.
  - Sustained throughput is 1 pixel/cycle.
- Simultaneous push and pop:
  - Allowed when the FIFO is not full; occupancy is unchanged.
  - Push when full is impossible by construction. Pop when empty is suppressed.
- Ordering: pixels from one source reach plot in acceptance order. Interleaving between sources follows grant order.
- Occupancy counter: width $clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
- idle = (occupancy==0) && !plot && !valid0 && !valid1.

Decomposition:
- Shared package (vga_pkg):
  - Constants SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=3.
  - Typedef pixel_t = packed {x[7:0], y[6:0], colour[2:0]}.
  - Colour constants BLACK=0, GREEN=2.
- Sub-module pixel_fifo: synchronous single-clock FIFO of pixel_t with push/pop/full/empty/count and asynchronous active-low reset. The arbiter, clipping, output register, idle and drop counter stay in plot_arbiter.

Test Plan:
- Single pixel: valid0 with (10,58,2) for one accepted cycle, FIFO empty. Required: ready0=1 that cycle; plot=1 exactly two edges later with x=10, y=58, colour=2; idle returns to 1 the cycle after plot drops.
- Contention: valid0 and valid1 held high for 8 cycles, distinct coordinates per beat. Required: grants alternate 0,1,0,1...; plot order matches grant order; no beat is lost or duplicated.
- Backpressure: 6 back-to-back pushes from source 1 while the output pops every cycle. Required: FIFO never exceeds DEPTH; ready1 stays 1 (steady state push and pop); all 6 pixels plotted in order.
- Clipping: source 0 sends (160,0), (0,120) and (159,119). Required: all three handshakes complete; only (159,119) is plotted; drop_count=2. A further 260 out-of-range pixels leave drop_count at 255.
- Reset mid-burst: fill the FIFO with 4 pixels, then assert resetn low asynchronously between edges. Required: plot=0, ready0=ready1=0, x=y=colour=0 immediately; after release the FIFO is empty and source 0 has priority.
- Idle with pending valid: FIFO empty, valid1 high. Required: idle=0 even though occupancy=0.
